// File: rtl/mem_arbiter.sv
// Two-requester SRAM arbiter: instruction fetch and MEM-stage load/store share one
// single-port SRAM. MEM has priority; each access runs IDLE -> ACCESS -> DONE.
module mem_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int SRAM_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                gnt_mem_q, gnt_mem_d;
  logic                cs_q, cs_d;
  logic                sram_we_q, sram_we_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                mem_ready_q, mem_ready_d;

  // Byte-offset and high address bits never reach the word-addressed SRAM.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                                mem_addr[1:0], mem_addr[31:ADDR_W+2]};

  // Next-state, capture and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    gnt_mem_d   = gnt_mem_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cs_d        = 1'b0;
    sram_we_d   = 1'b0;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_r_en || mem_w_en) begin
          // A simultaneous read+write request is performed as a store.
          addr_d    = mem_addr[ADDR_W+1:2];
          wdata_d   = mem_wdata;
          we_d      = mem_w_en;
          gnt_mem_d = 1'b1;
          cnt_d     = 4'(SRAM_WAIT);
          cs_d      = 1'b1;
          sram_we_d = mem_w_en;
          state_d   = S_ACCESS;
        end else if (if_req) begin
          addr_d    = if_addr[ADDR_W+1:2];
          we_d      = 1'b0;
          gnt_mem_d = 1'b0;
          cnt_d     = 4'(SRAM_WAIT);
          cs_d      = 1'b1;
          sram_we_d = 1'b0;
          state_d   = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_DONE;
          mem_ready_d = gnt_mem_q;
          if_ready_d  = ~gnt_mem_q;
          if (!we_q && gnt_mem_q) begin
            mem_rdata_d = sram_rdata;
          end else if (!we_q) begin
            if_rdata_d = sram_rdata;
          end else begin
            mem_rdata_d = mem_rdata_q;
          end
        end else begin
          cnt_d     = cnt_q - 4'd1;
          cs_d      = 1'b1;
          sram_we_d = we_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      gnt_mem_q   <= 1'b0;
      cs_q        <= 1'b0;
      sram_we_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      gnt_mem_q   <= gnt_mem_d;
      cs_q        <= cs_d;
      sram_we_q   <= sram_we_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign sram_cs    = cs_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_ready  = mem_ready_q;
  assign if_stall   = if_req & ~if_ready_q;
  assign mem_stall  = (mem_r_en | mem_w_en) & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (SRAM_WAIT=2), plus a second
// instance with SRAM_WAIT=0 for back-to-back fetch throughput.
module tb_mem_arbiter;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_r_en, mem_w_en;
  logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
  logic [31:0] if_rdata, mem_rdata, sram_wdata;
  logic        if_ready, mem_ready, if_stall, mem_stall, sram_cs, sram_we;
  logic [17:0] sram_addr;

  logic        if_req0;
  logic [31:0] if_rdata0, mem_rdata0, sram_wdata0;
  logic        if_ready0, mem_ready0, if_stall0, mem_stall0, sram_cs0, sram_we0;
  logic [17:0] sram_addr0;
  logic [31:0] zero32;
  logic [31:0] rdata0_const;
  logic        zero1;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(18), .SRAM_WAIT(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .if_stall(if_stall), .mem_stall(mem_stall),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  mem_arbiter #(.ADDR_W(18), .SRAM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req0), .if_addr(32'h0000_0040), .if_rdata(if_rdata0), .if_ready(if_ready0),
    .mem_r_en(zero1), .mem_w_en(zero1), .mem_addr(zero32), .mem_wdata(zero32),
    .mem_rdata(mem_rdata0), .mem_ready(mem_ready0), .if_stall(if_stall0), .mem_stall(mem_stall0),
    .sram_cs(sram_cs0), .sram_we(sram_we0), .sram_addr(sram_addr0), .sram_wdata(sram_wdata0),
    .sram_rdata(rdata0_const)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        r_en;
    logic        w_en;
    logic [31:0] m_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [17:0] exp_addr;
    logic        exp_we;
  } vec_t;

  vec_t vecs [7];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_if, exp_mem;
  int   ready_k, cs_n, other, mem_k, if_k, bad, both;
  logic is_mem;
  logic [17:0] first_addr;
  logic first_set;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, {63'd0, sram_cs}, 64'd0);
    check({tag, "_we"}, {63'd0, sram_we}, 64'd0);
    check({tag, "_addr"}, {46'd0, sram_addr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, sram_wdata}, 64'd0);
    check({tag, "_readys"}, {62'd0, if_ready, mem_ready}, 64'd0);
    check({tag, "_if_rdata"}, {32'd0, if_rdata}, 64'd0);
    check({tag, "_mem_rdata"}, {32'd0, mem_rdata}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2000_0005, 18'h00004, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1111_2222, 18'h00010, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h9999_9999, 18'h00002, 1'b1};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 32'h8888_8888, 18'h00003, 1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_C0DE, 18'h3FFFF, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0012_3454, 32'h0, 32'h0F0F_0F0F, 18'h08D15, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 18'h00008, 1'b0};

    rst = 1'b1; if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0; sram_rdata = 32'd0;
    if_req0 = 1'b0; zero32 = 32'd0; zero1 = 1'b0; rdata0_const = 32'h5A5A_0000;
    exp_if = 32'd0; exp_mem = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");

    // Single transactions from the vector table.
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      if_req = vecs[v].if_req; if_addr = vecs[v].if_addr;
      mem_r_en = vecs[v].r_en; mem_w_en = vecs[v].w_en;
      mem_addr = vecs[v].m_addr; mem_wdata = vecs[v].wdata; sram_rdata = vecs[v].rdata;
      is_mem = vecs[v].r_en | vecs[v].w_en;
      ready_k = 0; cs_n = 0; other = 0; bad = 0;
      for (int k = 1; k <= 12 && ready_k == 0; k++) begin
        @(posedge clk); #1;
        if (sram_cs) begin
          cs_n++;
          if (sram_addr !== vecs[v].exp_addr || sram_we !== vecs[v].exp_we) bad++;
          if (vecs[v].exp_we && sram_wdata !== vecs[v].wdata) bad++;
        end
        if (is_mem ? if_ready : mem_ready) other++;
        if (is_mem ? mem_ready : if_ready) begin
          ready_k = k;
          if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        end
      end
      if (!vecs[v].w_en) begin
        if (is_mem) exp_mem = vecs[v].rdata;
        else exp_if = vecs[v].rdata;
      end
      check($sformatf("v%0d_latency", v), 64'(ready_k), 64'(W + 2));
      check($sformatf("v%0d_cs_cycles", v), 64'(cs_n), 64'(W + 1));
      check($sformatf("v%0d_sram_bus", v), 64'(bad), 64'd0);
      check($sformatf("v%0d_wrong_ready", v), 64'(other), 64'd0);
      check($sformatf("v%0d_if_rdata", v), {32'd0, if_rdata}, {32'd0, exp_if});
      check($sformatf("v%0d_mem_rdata", v), {32'd0, mem_rdata}, {32'd0, exp_mem});
    end

    // MEM and IF requested together: MEM first, IF after the turnaround.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0100; mem_r_en = 1'b1; mem_addr = 32'h0000_0040;
    sram_rdata = 32'hAAAA_0001;
    mem_k = 0; if_k = 0; bad = 0; both = 0; first_set = 1'b0; first_addr = 18'd0;
    for (int k = 1; k <= 20 && if_k == 0; k++) begin
      @(posedge clk); #1;
      if (sram_cs && !first_set) begin first_addr = sram_addr; first_set = 1'b1; end
      if (!if_ready && !if_stall) bad++;
      if (mem_k == 0 && !mem_ready && !mem_stall) bad++;
      if (if_ready && mem_ready) both++;
      if (mem_ready) begin mem_k = k; mem_r_en = 1'b0; sram_rdata = 32'hBBBB_0002; end
      if (if_ready) begin if_k = k; if_req = 1'b0; end
    end
    exp_mem = 32'hAAAA_0001; exp_if = 32'hBBBB_0002;
    check("prio_mem_ready_cycle", 64'(mem_k), 64'(W + 2));
    check("prio_if_ready_cycle", 64'(if_k), 64'(2 * W + 5));
    check("prio_first_addr", {46'd0, first_addr}, 64'h10);
    check("prio_stall", 64'(bad), 64'd0);
    check("prio_both_ready", 64'(both), 64'd0);
    check("prio_mem_rdata", {32'd0, mem_rdata}, {32'd0, exp_mem});
    check("prio_if_rdata", {32'd0, if_rdata}, {32'd0, exp_if});

    // Request dropped and address changed right after grant.
    @(posedge clk); #1;
    mem_r_en = 1'b1; mem_addr = 32'h0000_0080; sram_rdata = 32'h7777_0003;
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_addr = 32'h0000_0044;
    #1;
    check("drop_mem_stall", {63'd0, mem_stall}, 64'd0);
    mem_k = 0; bad = 0;
    for (int k = 2; k <= 10 && mem_k == 0; k++) begin
      @(posedge clk); #1;
      if (sram_cs && sram_addr !== 18'h00020) bad++;
      if (mem_ready) mem_k = k;
    end
    exp_mem = 32'h7777_0003;
    check("drop_ready_cycle", 64'(mem_k), 64'(W + 2));
    check("drop_addr_held", 64'(bad), 64'd0);
    check("drop_mem_rdata", {32'd0, mem_rdata}, {32'd0, exp_mem});

    // Reset in the second ACCESS cycle, request held through reset.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0030; sram_rdata = 32'h1234_0000;
    @(posedge clk); @(posedge clk); #1;
    check("rst_pre_cs", {63'd0, sram_cs}, 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    exp_if = 32'd0; exp_mem = 32'd0;
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (sram_cs || if_ready || mem_ready) bad++;
    end
    check("rst_hold_quiet", 64'(bad), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_first_grant_cs", {63'd0, sram_cs}, 64'd1);
    check("rst_first_grant_addr", {46'd0, sram_addr}, 64'h0C);
    if_k = 0;
    for (int k = 2; k <= 10 && if_k == 0; k++) begin
      @(posedge clk); #1;
      if (if_ready) begin if_k = k; if_req = 1'b0; end
    end
    exp_if = 32'h1234_0000;
    check("rst_regrant_latency", 64'(if_k), 64'(W + 2));
    check("rst_regrant_if_rdata", {32'd0, if_rdata}, {32'd0, exp_if});
    check("rst_regrant_mem_rdata", {32'd0, mem_rdata}, {32'd0, exp_mem});

    // Zero-wait instance, continuous fetch: one ready every 3 cycles.
    @(posedge clk); #1;
    if_req0 = 1'b1;
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (if_ready0 !== (k % 3 == 2)) bad++;
      if (sram_cs0 !== (k % 3 == 1)) bad++;
    end
    if_req0 = 1'b0;
    check("w0_ready_cs_pattern", 64'(bad), 64'd0);
    check("w0_if_rdata", {32'd0, if_rdata0}, 64'h5A5A_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
